// File: rtl/mem_port_arbiter.sv
// Time-shares one single-ported DataMem between NUM_PORTS requesters; optional MEM_ARB_MISALIGN_CHECK_EN.
// Latency: grant and command same cycle; read data MEM_LAT cycles after its grant.
// Backpressure: requests hold until gnt; no grant while a read is outstanding except in its rvalid cycle.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter int ARB_RR    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  input  logic [NUM_PORTS*3-1:0]      funct3,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [2:0]                  mem_funct3,
  output logic [DATA_W-1:0]           mem_data_in,
`ifdef MEM_ARB_MISALIGN_CHECK_EN
  output logic [NUM_PORTS-1:0]        misalign_err,
`endif
  input  logic [DATA_W-1:0]           mem_data_out
);

  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [2:0]      cnt, cnt_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]   winner;
  logic            found;
  logic            resp;
  logic            issue;
  logic            bad;
  logic            w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [2:0]      w_funct3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      owner  <= '0;
      rr_ptr <= PW'(NUM_PORTS - 1);
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Winner search: round-robin starts just after the last winner, fixed scans from port 0.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    if (ARB_RR != 0) begin
      for (int i = 1; i <= NUM_PORTS; i++) begin
        if (!found && req[(int'(rr_ptr) + i) % NUM_PORTS]) begin
          found  = 1'b1;
          winner = PW'((int'(rr_ptr) + i) % NUM_PORTS);
        end
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && req[i]) begin
          found  = 1'b1;
          winner = PW'(i);
        end
      end
    end
  end

  assign w_we     = we[winner];
  assign w_addr   = addr[int'(winner)*ADDR_W +: ADDR_W];
  assign w_wdata  = wdata[int'(winner)*DATA_W +: DATA_W];
  assign w_funct3 = funct3[int'(winner)*3 +: 3];

  // The rvalid cycle of an outstanding read doubles as a grant slot for back-to-back reads.
  assign resp  = (state == WAIT) && (cnt == 3'd0);
  assign issue = found && ((state == IDLE) || resp);

`ifdef MEM_ARB_MISALIGN_CHECK_EN
  assign bad = ((w_funct3[1:0] == 2'b01) && w_addr[0]) ||
               ((w_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    gnt         = '0;
    rvalid      = '0;
    rdata       = '0;
    mem_addr    = '0;
    mem_funct3  = '0;
    mem_data_in = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    misalign_err = '0;
`endif
    state_nxt   = IDLE;
    cnt_nxt     = '0;
    owner_nxt   = owner;
    rr_ptr_nxt  = rr_ptr;

    if (resp) begin
      rvalid[owner] = 1'b1;
      rdata         = mem_data_out;
    end

    if (issue) begin
      gnt[winner] = 1'b1;
      mem_addr    = w_addr;
      mem_funct3  = w_funct3;
      mem_data_in = w_wdata;
      mem_write   = w_we && !bad;
      mem_read    = !w_we && !bad;
      rr_ptr_nxt  = winner;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
      misalign_err[winner] = bad;
`endif
    end

    if (mem_read) begin
      state_nxt = WAIT;
      cnt_nxt   = 3'(MEM_LAT - 1);
      owner_nxt = winner;
    end else if ((state == WAIT) && (cnt != 3'd0)) begin
      state_nxt = WAIT;
      cnt_nxt   = cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances cover fixed priority (lat 1),
// round-robin with three ports (lat 1) and a three-cycle-latency memory.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: 2 ports, MEM_LAT=1, fixed priority
  logic        rst_a;
  logic [1:0]  req_a, we_a, gnt_a, rvalid_a;
  logic [17:0] addr_a;
  logic [63:0] wdata_a;
  logic [5:0]  f3_a;
  logic [31:0] rdata_a, mdin_a, mdout_a;
  logic [8:0]  maddr_a;
  logic        mrd_a, mwr_a;
  logic [2:0]  mf3_a;

  // Instance B: 3 ports, MEM_LAT=1, round-robin
  logic        rst_b;
  logic [2:0]  req_b, we_b, gnt_b, rvalid_b;
  logic [26:0] addr_b;
  logic [95:0] wdata_b;
  logic [8:0]  f3_b;
  logic [31:0] rdata_b, mdin_b, mdout_b;
  logic [8:0]  maddr_b;
  logic        mrd_b, mwr_b;
  logic [2:0]  mf3_b;

  // Instance C: 2 ports, MEM_LAT=3, fixed priority
  logic        rst_c;
  logic [1:0]  req_c, we_c, gnt_c, rvalid_c;
  logic [17:0] addr_c;
  logic [63:0] wdata_c;
  logic [5:0]  f3_c;
  logic [31:0] rdata_c, mdin_c, mdout_c;
  logic [8:0]  maddr_c;
  logic        mrd_c, mwr_c;
  logic [2:0]  mf3_c;

`ifdef MEM_ARB_MISALIGN_CHECK_EN
  logic [1:0] merr_a, merr_c;
  logic [2:0] merr_b;
`endif

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(9), .DATA_W(32), .MEM_LAT(1), .ARB_RR(0)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .funct3(f3_a), .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a), .mem_addr(maddr_a),
    .mem_read(mrd_a), .mem_write(mwr_a), .mem_funct3(mf3_a), .mem_data_in(mdin_a),
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    .misalign_err(merr_a),
`endif
    .mem_data_out(mdout_a));

  mem_port_arbiter #(.NUM_PORTS(3), .ADDR_W(9), .DATA_W(32), .MEM_LAT(1), .ARB_RR(1)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .funct3(f3_b), .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .mem_addr(maddr_b),
    .mem_read(mrd_b), .mem_write(mwr_b), .mem_funct3(mf3_b), .mem_data_in(mdin_b),
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    .misalign_err(merr_b),
`endif
    .mem_data_out(mdout_b));

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(9), .DATA_W(32), .MEM_LAT(3), .ARB_RR(0)) dut_c (
    .clk(clk), .rst(rst_c), .req(req_c), .we(we_c), .addr(addr_c), .wdata(wdata_c),
    .funct3(f3_c), .gnt(gnt_c), .rvalid(rvalid_c), .rdata(rdata_c), .mem_addr(maddr_c),
    .mem_read(mrd_c), .mem_write(mwr_c), .mem_funct3(mf3_c), .mem_data_in(mdin_c),
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    .misalign_err(merr_c),
`endif
    .mem_data_out(mdout_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    step(); step();
    @(negedge clk);
    n_cmp++; if (gnt_a !== 2'b00 || rvalid_a !== 2'b00) begin n_bad++; $display("FAIL reset_a_hs: gnt=%b rvalid=%b want 00/00", gnt_a, rvalid_a); end
    n_cmp++; if (mrd_a !== 1'b0 || mwr_a !== 1'b0 || maddr_a !== 9'h0) begin n_bad++; $display("FAIL reset_a_mem: rd=%b wr=%b addr=%h want 0/0/000", mrd_a, mwr_a, maddr_a); end
    n_cmp++; if (gnt_b !== 3'b000 || rvalid_b !== 3'b000 || mrd_b !== 1'b0) begin n_bad++; $display("FAIL reset_b: gnt=%b rvalid=%b rd=%b want 0", gnt_b, rvalid_b, mrd_b); end
    n_cmp++; if (gnt_c !== 2'b00 || rvalid_c !== 2'b00 || mwr_c !== 1'b0) begin n_bad++; $display("FAIL reset_c: gnt=%b rvalid=%b wr=%b want 0", gnt_c, rvalid_c, mwr_c); end
    step();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
  endtask

  task automatic test_single_read();
    req_a = 2'b01; we_a = 2'b00; addr_a = {9'h0, 9'h010}; f3_a = {3'b000, 3'b010};
    @(negedge clk);
    n_cmp++; if (gnt_a !== 2'b01 || mrd_a !== 1'b1 || mwr_a !== 1'b0) begin n_bad++; $display("FAIL single_gnt: gnt=%b rd=%b wr=%b want 01/1/0", gnt_a, mrd_a, mwr_a); end
    n_cmp++; if (maddr_a !== 9'h010 || mf3_a !== 3'b010) begin n_bad++; $display("FAIL single_cmd: addr=%h f3=%b want 010/010", maddr_a, mf3_a); end
    step();
    req_a = 2'b00; mdout_a = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++; if (rvalid_a !== 2'b01 || rdata_a !== 32'hDEADBEEF || gnt_a !== 2'b00) begin n_bad++; $display("FAIL single_resp: rvalid=%b rdata=%h gnt=%b want 01/deadbeef/00", rvalid_a, rdata_a, gnt_a); end
    step();
    @(negedge clk);
    n_cmp++; if (rvalid_a !== 2'b00) begin n_bad++; $display("FAIL single_drain: rvalid=%b want 00", rvalid_a); end
    step();
  endtask

  task automatic test_fixed_priority();
    req_a = 2'b11; we_a = 2'b00; addr_a = {9'h020, 9'h010}; f3_a = {3'b010, 3'b010};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (gnt_a !== 2'b01 || maddr_a !== 9'h010) begin n_bad++; $display("FAIL fixed_hold%0d: gnt=%b addr=%h want 01/010", k, gnt_a, maddr_a); end
      if (k > 0) begin
        n_cmp++; if (rvalid_a !== 2'b01) begin n_bad++; $display("FAIL fixed_rv%0d: rvalid=%b want 01", k, rvalid_a); end
      end
      step();
    end
    req_a = 2'b10;
    @(negedge clk);
    n_cmp++; if (gnt_a !== 2'b10 || maddr_a !== 9'h020 || rvalid_a !== 2'b01) begin n_bad++; $display("FAIL fixed_p1: gnt=%b addr=%h rvalid=%b want 10/020/01", gnt_a, maddr_a, rvalid_a); end
    step();
    req_a = 2'b00;
    @(negedge clk);
    n_cmp++; if (gnt_a !== 2'b00 || rvalid_a !== 2'b10) begin n_bad++; $display("FAIL fixed_p1_resp: gnt=%b rvalid=%b want 00/10", gnt_a, rvalid_a); end
    step();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    logic [2:0] exp_r [4];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    exp_r[0] = 3'b000; exp_r[1] = 3'b001; exp_r[2] = 3'b010; exp_r[3] = 3'b100;
    req_b = 3'b111; we_b = 3'b000; addr_b = {9'h003, 9'h002, 9'h001}; f3_b = {3'b010, 3'b010, 3'b010};
    mdout_b = 32'h0BADF00D;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (gnt_b !== exp_g[k] || rvalid_b !== exp_r[k]) begin n_bad++; $display("FAIL rr_seq%0d: gnt=%b rvalid=%b want %b/%b", k, gnt_b, rvalid_b, exp_g[k], exp_r[k]); end
      step();
    end
    req_b = 3'b000;
    @(negedge clk);
    n_cmp++; if (gnt_b !== 3'b000 || rvalid_b !== 3'b001 || rdata_b !== 32'h0BADF00D) begin n_bad++; $display("FAIL rr_tail: gnt=%b rvalid=%b rdata=%h want 000/001/0badf00d", gnt_b, rvalid_b, rdata_b); end
    step();
  endtask

  task automatic test_latency_busy();
    req_c = 2'b10; we_c = 2'b00; addr_c = {9'h044, 9'h000}; f3_c = {3'b010, 3'b010}; wdata_c = '0;
    @(negedge clk);
    n_cmp++; if (gnt_c !== 2'b10 || mrd_c !== 1'b1 || maddr_c !== 9'h044) begin n_bad++; $display("FAIL lat_gnt: gnt=%b rd=%b addr=%h want 10/1/044", gnt_c, mrd_c, maddr_c); end
    step();
    req_c = 2'b01; we_c = 2'b01; addr_c = {9'h000, 9'h055}; wdata_c = {32'h0, 32'h12345678};
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_cmp++; if (gnt_c !== 2'b00 || rvalid_c !== 2'b00 || mwr_c !== 1'b0) begin n_bad++; $display("FAIL lat_busy%0d: gnt=%b rvalid=%b wr=%b want 00/00/0", k, gnt_c, rvalid_c, mwr_c); end
      step();
    end
    mdout_c = 32'hCAFEF00D;
    @(negedge clk);
    n_cmp++; if (gnt_c !== 2'b01 || mwr_c !== 1'b1 || mrd_c !== 1'b0) begin n_bad++; $display("FAIL lat_wr: gnt=%b wr=%b rd=%b want 01/1/0", gnt_c, mwr_c, mrd_c); end
    n_cmp++; if (maddr_c !== 9'h055 || mdin_c !== 32'h12345678) begin n_bad++; $display("FAIL lat_wr_cmd: addr=%h din=%h want 055/12345678", maddr_c, mdin_c); end
    n_cmp++; if (rvalid_c !== 2'b10 || rdata_c !== 32'hCAFEF00D) begin n_bad++; $display("FAIL lat_resp: rvalid=%b rdata=%h want 10/cafef00d", rvalid_c, rdata_c); end
    step();
    req_c = 2'b00; we_c = 2'b00;
    @(negedge clk);
    n_cmp++; if (gnt_c !== 2'b00 || rvalid_c !== 2'b00) begin n_bad++; $display("FAIL lat_after_wr: gnt=%b rvalid=%b want 00/00", gnt_c, rvalid_c); end
    step();
  endtask

  task automatic test_reset_mid_read();
    req_c = 2'b01; we_c = 2'b00; addr_c = {9'h000, 9'h008}; mdout_c = 32'h55AA55AA;
    @(negedge clk);
    n_cmp++; if (gnt_c !== 2'b01 || mrd_c !== 1'b1) begin n_bad++; $display("FAIL rstmid_gnt: gnt=%b rd=%b want 01/1", gnt_c, mrd_c); end
    step();
    req_c = 2'b00; rst_c = 1'b1;
    step();
    rst_c = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++; if (rvalid_c !== 2'b00 || rdata_c !== 32'h0 || gnt_c !== 2'b00) begin n_bad++; $display("FAIL rstmid_rv%0d: rvalid=%b rdata=%h gnt=%b want 00/0/00", k, rvalid_c, rdata_c, gnt_c); end
      n_cmp++; if (mrd_c !== 1'b0 || mwr_c !== 1'b0 || maddr_c !== 9'h0 || mdin_c !== 32'h0) begin n_bad++; $display("FAIL rstmid_out%0d: rd=%b wr=%b addr=%h din=%h want 0", k, mrd_c, mwr_c, maddr_c, mdin_c); end
      step();
    end
    req_c = 2'b10; addr_c = {9'h0FF, 9'h000};
    @(negedge clk);
    n_cmp++; if (gnt_c !== 2'b10 || maddr_c !== 9'h0FF) begin n_bad++; $display("FAIL rstmid_recover: gnt=%b addr=%h want 10/0ff", gnt_c, maddr_c); end
    step();
    req_c = 2'b00;
    step(); step(); step();
  endtask

  task automatic test_back_to_back();
    req_a = 2'b01; we_a = 2'b01; addr_a = {9'h0, 9'h0A0}; wdata_a = {32'h0, 32'h00000011}; f3_a = {3'b010, 3'b010};
    @(negedge clk);
    n_cmp++; if (gnt_a !== 2'b01 || mwr_a !== 1'b1 || mdin_a !== 32'h11) begin n_bad++; $display("FAIL b2b_w0: gnt=%b wr=%b din=%h want 01/1/11", gnt_a, mwr_a, mdin_a); end
    step();
    addr_a = {9'h0, 9'h0A4}; wdata_a = {32'h0, 32'h00000022};
    @(negedge clk);
    n_cmp++; if (gnt_a !== 2'b01 || mwr_a !== 1'b1 || mdin_a !== 32'h22 || maddr_a !== 9'h0A4 || rvalid_a !== 2'b00) begin n_bad++; $display("FAIL b2b_w1: gnt=%b wr=%b din=%h addr=%h rvalid=%b", gnt_a, mwr_a, mdin_a, maddr_a, rvalid_a); end
    step();
    req_a = 2'b00; we_a = 2'b00;
    @(negedge clk);
    n_cmp++; if (gnt_a !== 2'b00 || rvalid_a !== 2'b00 || mwr_a !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: gnt=%b rvalid=%b wr=%b want 0", gnt_a, rvalid_a, mwr_a); end
    step();
  endtask

  task automatic test_misalign();
    req_a = 2'b01; we_a = 2'b00; addr_a = {9'h0, 9'h003}; f3_a = {3'b000, 3'b001}; mdout_a = 32'h00001234;
    @(negedge clk);
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    n_cmp++; if (gnt_a !== 2'b01 || merr_a !== 2'b01 || mrd_a !== 1'b0) begin n_bad++; $display("FAIL mis_gnt: gnt=%b err=%b rd=%b want 01/01/0", gnt_a, merr_a, mrd_a); end
`else
    n_cmp++; if (gnt_a !== 2'b01 || mrd_a !== 1'b1 || maddr_a !== 9'h003 || mf3_a !== 3'b001) begin n_bad++; $display("FAIL mis_fwd: gnt=%b rd=%b addr=%h f3=%b want 01/1/003/001", gnt_a, mrd_a, maddr_a, mf3_a); end
`endif
    step();
    req_a = 2'b00;
    @(negedge clk);
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    n_cmp++; if (rvalid_a !== 2'b00 || merr_a !== 2'b00) begin n_bad++; $display("FAIL mis_norv: rvalid=%b err=%b want 00/00", rvalid_a, merr_a); end
`else
    n_cmp++; if (rvalid_a !== 2'b01 || rdata_a !== 32'h00001234) begin n_bad++; $display("FAIL mis_fwd_rv: rvalid=%b rdata=%h want 01/00001234", rvalid_a, rdata_a); end
`endif
    step();
  endtask

  initial begin
    req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0; f3_a = '0; mdout_a = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0; f3_b = '0; mdout_b = '0;
    req_c = '0; we_c = '0; addr_c = '0; wdata_c = '0; f3_c = '0; mdout_c = '0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #1;
    test_reset();
    test_single_read();
    test_fixed_priority();
    test_round_robin();
    test_latency_busy();
    test_reset_mid_read();
    test_back_to_back();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
